// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_reader
//  Description : Read-side companion to the multi-port register file. Walks a
//                programmable (optionally wrapping) address range through one
//                register-file read port and streams each word out over a
//                valid/ready handshake. Optional running checksum of the
//                accepted words is enabled by defining REG_DUMP_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_reader #(
    parameter int ADDR = 4,
    parameter int SIZE = 32
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            Start,
    input  logic            Abort,
    input  logic [ADDR-1:0] Start_Addr,
    input  logic [ADDR-1:0] End_Addr,
    output logic [ADDR-1:0] R_Addr,
    input  logic [SIZE-1:0] R_Data,
    output logic [SIZE-1:0] Out_Data,
    output logic [ADDR-1:0] Out_Addr,
    output logic            Out_Last,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic            Busy,
    output logic            Done
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    output logic [SIZE-1:0] Sum
`endif
);

    // Register count follows from the address width; not meant to be overridden.
    localparam int NUMB = 1 << ADDR;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_READ = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [ADDR-1:0] r_cur;
    logic [ADDR-1:0] r_end;
    logic [SIZE-1:0] r_out_data;
    logic [ADDR-1:0] r_out_addr;
    logic            r_out_last;
    logic            r_out_valid;
    logic            r_busy;
    logic            r_done;

    logic [ADDR-1:0] w_next_cur;
    logic            w_start;
    logic            w_accept;

    // Pointer advance wraps explicitly at the top of the register file.
    assign w_next_cur = (r_cur == ADDR'(NUMB - 1)) ? '0 : r_cur + 1'b1;
    assign w_start    = (r_state == c_IDLE) && Start;
    // Abort wins over a simultaneous transfer, so it suppresses acceptance.
    assign w_accept   = (r_state == c_HOLD) && Out_Ready && !Abort;

    assign R_Addr    = r_cur;
    assign Out_Data  = r_out_data;
    assign Out_Addr  = r_out_addr;
    assign Out_Last  = r_out_last;
    assign Out_Valid = r_out_valid;
    assign Busy      = r_busy;
    assign Done      = r_done;

    // Dump sequencer: range latch, read/capture, handshake hold and completion.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state     <= c_IDLE;
            r_cur       <= '0;
            r_end       <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Start) begin
                        r_cur   <= Start_Addr;
                        r_end   <= End_Addr;
                        r_busy  <= 1'b1;
                        r_state <= c_READ;
                    end
                end
                c_READ: begin
                    if (Abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= c_IDLE;
                    end else begin
                        r_out_data  <= R_Data;
                        r_out_addr  <= r_cur;
                        r_out_last  <= (r_cur == r_end);
                        r_out_valid <= 1'b1;
                        r_state     <= c_HOLD;
                    end
                end
                c_HOLD: begin
                    if (Abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= c_IDLE;
                    end else if (Out_Ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end else begin
                            r_cur   <= w_next_cur;
                            r_state <= c_READ;
                        end
                    end
                end
                default: begin
                    // c_DONE: single-cycle completion pulse, Start ignored here.
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [SIZE-1:0] r_sum;

    assign Sum = r_sum;

    // Running modulo-2^SIZE sum of every word the consumer accepts.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_sum <= '0;
        end else if (w_start) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= r_sum + r_out_data;
        end
    end
`else
    // Without the checksum the start/accept decodes have no consumer.
    logic w_unused;
    assign w_unused = w_start ^ w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_dump_reader
//  Description : Self-checking bench for reg_dump_reader. Table of dump
//                ranges plus directed stall / abort / reset sequences.
//                Checksum checks follow REG_DUMP_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_reader;

    logic        Clk;
    logic        Clr;
    logic        Start;
    logic        Abort;
    logic [3:0]  Start_Addr;
    logic [3:0]  End_Addr;
    logic [3:0]  R_Addr;
    logic [31:0] R_Data;
    logic [31:0] Out_Data;
    logic [3:0]  Out_Addr;
    logic        Out_Last;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Busy;
    logic        Done;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] Sum;
`endif

    logic [31:0] regs [16];
    int n_checks;
    int n_errors;

    typedef struct {
        logic [3:0]  sa;
        logic [3:0]  ea;
        int          n;
        logic [31:0] sum;
        bit          noisy;
    } vec_t;

    vec_t vecs [7];

    reg_dump_reader #(.ADDR(4), .SIZE(32)) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .Start      (Start),
        .Abort      (Abort),
        .Start_Addr (Start_Addr),
        .End_Addr   (End_Addr),
        .R_Addr     (R_Addr),
        .R_Data     (R_Data),
        .Out_Data   (Out_Data),
        .Out_Addr   (Out_Addr),
        .Out_Last   (Out_Last),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Busy       (Busy),
        .Done       (Done)
`ifdef REG_DUMP_CHECKSUM_EN
        ,
        .Sum        (Sum)
`endif
    );

    // Register file read port model.
    assign R_Data = regs[R_Addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_sum(input logic [31:0] exp);
`ifdef REG_DUMP_CHECKSUM_EN
        check("sum", Sum, exp);
`else
        if (exp === 32'hx) $display("unused");
`endif
    endtask

    // Full dump with Out_Ready high; entered and left 1 time unit after an edge.
    task automatic run_dump(input logic [3:0] sa, input logic [3:0] ea, input int n,
                            input logic [31:0] esum, input bit noisy);
        logic [3:0] a;
        Start_Addr = sa;
        End_Addr   = ea;
        Start      = 1'b1;
        Out_Ready  = 1'b1;
        step();
        Start = noisy;
        check("start_busy", {31'd0, Busy}, 32'd1);
        check("start_raddr", {28'd0, R_Addr}, {28'd0, sa});
        check("start_valid", {31'd0, Out_Valid}, 32'd0);
        check("start_done", {31'd0, Done}, 32'd0);
        a = sa;
        for (int i = 0; i < n; i++) begin
            if (noisy) begin
                Start_Addr = 4'($urandom_range(0, 15));
                End_Addr   = 4'($urandom_range(0, 15));
            end
            step();
            check("w_valid", {31'd0, Out_Valid}, 32'd1);
            check("w_addr", {28'd0, Out_Addr}, {28'd0, a});
            check("w_raddr", {28'd0, R_Addr}, {28'd0, a});
            check("w_data", Out_Data, regs[a]);
            check("w_last", {31'd0, Out_Last}, (i == n - 1) ? 32'd1 : 32'd0);
            check("w_busy", {31'd0, Busy}, 32'd1);
            step();
            check("acc_valid", {31'd0, Out_Valid}, 32'd0);
            check("acc_done", {31'd0, Done}, (i == n - 1) ? 32'd1 : 32'd0);
            check("acc_busy", {31'd0, Busy}, (i == n - 1) ? 32'd0 : 32'd1);
            a = a + 4'd1;
        end
        check_sum(esum);
        step();
        Start = 1'b0;
        check("post_done", {31'd0, Done}, 32'd0);
        check("post_busy", {31'd0, Busy}, 32'd0);
        check_sum(esum);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < 16; k++) regs[k] = 32'd0;
        regs[0]  = 32'd1;
        regs[8]  = 32'd2;
        regs[13] = 32'd3;

        vecs[0] = '{sa: 4'd0,  ea: 4'd15, n: 16, sum: 32'd6, noisy: 1'b0};
        vecs[1] = '{sa: 4'd13, ea: 4'd8,  n: 12, sum: 32'd6, noisy: 1'b0};
        vecs[2] = '{sa: 4'd8,  ea: 4'd8,  n: 1,  sum: 32'd2, noisy: 1'b0};
        vecs[3] = '{sa: 4'd5,  ea: 4'd4,  n: 16, sum: 32'd6, noisy: 1'b0};
        vecs[4] = '{sa: 4'd14, ea: 4'd1,  n: 4,  sum: 32'd1, noisy: 1'b0};
        vecs[5] = '{sa: 4'd3,  ea: 4'd7,  n: 5,  sum: 32'd0, noisy: 1'b0};
        vecs[6] = '{sa: 4'd13, ea: 4'd8,  n: 12, sum: 32'd6, noisy: 1'b1};

        Clr        = 1'b1;
        Start      = 1'b0;
        Abort      = 1'b0;
        Out_Ready  = 1'b1;
        Start_Addr = 4'd0;
        End_Addr   = 4'd0;
        step();
        step();
        check("rst_raddr", {28'd0, R_Addr}, 32'd0);
        check("rst_data", Out_Data, 32'd0);
        check("rst_addr", {28'd0, Out_Addr}, 32'd0);
        check("rst_last", {31'd0, Out_Last}, 32'd0);
        check("rst_valid", {31'd0, Out_Valid}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check_sum(32'd0);
        Clr = 1'b0;
        step();
        check("idle_busy", {31'd0, Busy}, 32'd0);

        // Table of dump ranges.
        for (int v = 0; v < 7; v++) begin
            run_dump(vecs[v].sa, vecs[v].ea, vecs[v].n, vecs[v].sum, vecs[v].noisy);
        end

        // Consumer stall on the first word.
        Out_Ready  = 1'b0;
        Start_Addr = 4'd0;
        End_Addr   = 4'd15;
        Start      = 1'b1;
        step();
        Start = 1'b0;
        step();
        check("stall_first_valid", {31'd0, Out_Valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_valid", {31'd0, Out_Valid}, 32'd1);
            check("stall_data", Out_Data, 32'd1);
            check("stall_addr", {28'd0, Out_Addr}, 32'd0);
        end
        Out_Ready = 1'b1;
        step();
        check("stall_acc_valid", {31'd0, Out_Valid}, 32'd0);
        step();
        check("stall_next_addr", {28'd0, Out_Addr}, 32'd1);
        check("stall_next_valid", {31'd0, Out_Valid}, 32'd1);
        Abort     = 1'b1;
        Out_Ready = 1'b0;
        step();
        Abort = 1'b0;
        check("stall_abort_valid", {31'd0, Out_Valid}, 32'd0);
        check("stall_abort_busy", {31'd0, Busy}, 32'd0);
        step();
        check("stall_abort_done", {31'd0, Done}, 32'd0);

        // Abort together with a transfer on the 3rd word's HOLD cycle.
        Out_Ready  = 1'b1;
        Start_Addr = 4'd11;
        End_Addr   = 4'd15;
        Start      = 1'b1;
        step();
        Start = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        check("ab_pre_valid", {31'd0, Out_Valid}, 32'd1);
        check("ab_pre_addr", {28'd0, Out_Addr}, 32'd13);
        check("ab_pre_data", Out_Data, 32'd3);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("ab_valid", {31'd0, Out_Valid}, 32'd0);
        check("ab_last", {31'd0, Out_Last}, 32'd0);
        check("ab_busy", {31'd0, Busy}, 32'd0);
        check("ab_done", {31'd0, Done}, 32'd0);
        check_sum(32'd0);
        run_dump(4'd8, 4'd8, 1, 32'd2, 1'b0);

        // Asynchronous reset mid-dump.
        Start_Addr = 4'd0;
        End_Addr   = 4'd15;
        Start      = 1'b1;
        step();
        Start = 1'b0;
        for (int e = 1; e <= 3; e++) step();
        check("clr_pre_busy", {31'd0, Busy}, 32'd1);
        #2;
        Clr = 1'b1;
        #1;
        check("clr_raddr", {28'd0, R_Addr}, 32'd0);
        check("clr_data", Out_Data, 32'd0);
        check("clr_addr", {28'd0, Out_Addr}, 32'd0);
        check("clr_valid", {31'd0, Out_Valid}, 32'd0);
        check("clr_busy", {31'd0, Busy}, 32'd0);
        check("clr_done", {31'd0, Done}, 32'd0);
        check_sum(32'd0);
        @(negedge Clk);
        Clr = 1'b0;
        step();
        check("clr_post_busy", {31'd0, Busy}, 32'd0);
        check("clr_post_valid", {31'd0, Out_Valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
